// File: rtl/vending_pkg.sv
// Shared definitions for the vending machine key front end: entry state
// encoding, coin values, field widths and key slot indices.
package vending_pkg;

    typedef enum logic [1:0] {
        SEL_HIGH = 2'd0,
        SEL_LOW  = 2'd1,
        SEL_NUM  = 2'd2,
        PAY      = 2'd3
    } entry_state_t;

    localparam logic [3:0] COIN_1  = 4'd1;
    localparam logic [3:0] COIN_5  = 4'd5;
    localparam logic [3:0] COIN_10 = 4'd10;

    localparam int HIGH_W = 3;
    localparam int LOW_W  = 3;
    localparam int NUM_W  = 2;

    localparam int KEY_COUNT   = 7;
    localparam int KEY_UP      = 0;
    localparam int KEY_NEXT    = 1;
    localparam int KEY_CONFIRM = 2;
    localparam int KEY_CANCEL  = 3;
    localparam int KEY_COIN0   = 4;

    // Increment a selection field, wrapping from its maximum back to 1.
    function automatic logic [2:0] wrap_inc(input logic [2:0] value, input logic [2:0] max_value);
        return (value >= max_value) ? 3'd1 : value + 3'd1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button conditioner: 2-flop synchroniser, stability counter and a
// one-cycle press pulse on the debounced 0->1 transition.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_raw,
    output logic key_stable,
    output logic key_press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_armed;
    logic             r_stable;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;
    logic             w_settled;

    assign w_settled  = (r_cnt == CNT_LAST);
    assign key_stable = r_stable;
    assign key_press  = r_press;

    // Synchroniser keeps sampling through reset so a key held across reset
    // is still seen as high afterwards and cannot masquerade as a new press.
    always_ff @(posedge sys_clk) begin
        r_sync1 <= key_raw;
        r_sync2 <= r_sync1;
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_armed  <= 1'b0;
            r_stable <= 1'b0;
            r_press  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_armed <= r_armed | ~r_sync2;
            r_press <= 1'b0;
            if (!r_armed || (r_sync2 == r_stable)) begin
                r_cnt <= '0;
            end else if (w_settled) begin
                r_cnt    <= '0;
                r_stable <= r_sync2;
                r_press  <= r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vending_key_input.sv
// Vending machine key front end: debounced keys drive the goods-selection FSM
// and the PAY-state event pulses. VENDING_KEY_AUTO_REPEAT_EN adds key_up repeat.
module vending_key_input
    import vending_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HIGH_MAX        = 3,
    parameter int LOW_MAX         = 4,
    parameter int NUM_MAX         = 3,
    parameter int REPEAT_CYCLES   = 30_000_000
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              key_up,
    input  logic              key_next,
    input  logic              key_confirm,
    input  logic              key_cancel,
    input  logic [2:0]        key_coin,
    input  logic              trade_done,
    output logic [HIGH_W-1:0] in_goods_high,
    output logic [LOW_W-1:0]  in_goods_low,
    output logic [NUM_W-1:0]  in_goods_num,
    output logic [1:0]        entry_field,
    output logic              sel_valid,
    output logic              coin_pulse,
    output logic [3:0]        coin_value,
    output logic              confirm_pulse,
    output logic              cancel_pulse
);

    logic [KEY_COUNT-1:0] w_key_raw;
    logic [KEY_COUNT-1:0] w_key_stable;
    logic [KEY_COUNT-1:0] w_key_press;
    logic                 w_unused_stable;

    logic                 w_up_evt;
    logic                 w_next_evt;
    logic                 w_confirm_evt;
    logic                 w_cancel_evt;
    logic [2:0]           w_coin_evt;

    entry_state_t         r_state;
    logic [HIGH_W-1:0]    r_high;
    logic [LOW_W-1:0]     r_low;
    logic [NUM_W-1:0]     r_num;
    logic                 r_sel_valid;
    logic                 r_coin_pulse;
    logic [3:0]           r_coin_value;
    logic                 r_confirm_pulse;
    logic                 r_cancel_pulse;

    assign w_key_raw = {key_coin, key_cancel, key_confirm, key_next, key_up};

    genvar gi;
    generate
        for (gi = 0; gi < KEY_COUNT; gi++) begin : g_key
            key_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .sys_clk   (sys_clk),
                .sys_rst_n (sys_rst_n),
                .key_raw   (w_key_raw[gi]),
                .key_stable(w_key_stable[gi]),
                .key_press (w_key_press[gi])
            );
        end
    endgenerate

    assign w_unused_stable = ^w_key_stable;
    assign w_next_evt      = w_key_press[KEY_NEXT];
    assign w_confirm_evt   = w_key_press[KEY_CONFIRM];
    assign w_cancel_evt    = w_key_press[KEY_CANCEL];
    assign w_coin_evt      = w_key_press[KEY_COIN0 +: 3];

`ifdef VENDING_KEY_AUTO_REPEAT_EN
    localparam int REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

    logic [REP_W-1:0] r_rep_cnt;
    entry_state_t     r_rep_state;
    logic             w_rep_clear;
    logic             w_rep_tick;

    // The repeat period restarts at each genuine press and on any state change.
    assign w_rep_clear = !w_key_stable[KEY_UP] || (r_state == PAY) ||
                         (r_state != r_rep_state) || w_key_press[KEY_UP];
    assign w_rep_tick  = !w_rep_clear && (r_rep_cnt == REP_LAST);
    assign w_up_evt    = w_key_press[KEY_UP] | w_rep_tick;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_rep_cnt   <= '0;
            r_rep_state <= SEL_HIGH;
        end else begin
            r_rep_state <= r_state;
            if (w_rep_clear || w_rep_tick) begin
                r_rep_cnt <= '0;
            end else begin
                r_rep_cnt <= r_rep_cnt + 1'b1;
            end
        end
    end
`else
    localparam int unused_repeat_cycles = REPEAT_CYCLES;
    assign w_up_evt = w_key_press[KEY_UP];
`endif

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state         <= SEL_HIGH;
            r_high          <= 3'd1;
            r_low           <= 3'd1;
            r_num           <= 2'd1;
            r_sel_valid     <= 1'b0;
            r_coin_pulse    <= 1'b0;
            r_coin_value    <= 4'd0;
            r_confirm_pulse <= 1'b0;
            r_cancel_pulse  <= 1'b0;
        end else begin
            r_coin_pulse    <= 1'b0;
            r_coin_value    <= 4'd0;
            r_confirm_pulse <= 1'b0;
            r_cancel_pulse  <= 1'b0;
            if (w_cancel_evt || trade_done) begin
                // Abort and trade completion share the return path; coins are dropped.
                r_state        <= SEL_HIGH;
                r_high         <= 3'd1;
                r_low          <= 3'd1;
                r_num          <= 2'd1;
                r_sel_valid    <= 1'b0;
                r_cancel_pulse <= w_cancel_evt;
            end else begin
                if (w_confirm_evt) begin
                    if (r_state == SEL_NUM) begin
                        r_state     <= PAY;
                        r_sel_valid <= 1'b1;
                    end else if (r_state == PAY) begin
                        r_confirm_pulse <= 1'b1;
                    end
                end else if (w_next_evt) begin
                    case (r_state)
                        SEL_HIGH: r_state <= SEL_LOW;
                        SEL_LOW:  r_state <= SEL_NUM;
                        SEL_NUM:  r_state <= SEL_HIGH;
                        default:  r_state <= r_state;
                    endcase
                end else if (w_up_evt) begin
                    case (r_state)
                        SEL_HIGH: r_high <= wrap_inc(r_high, 3'(HIGH_MAX));
                        SEL_LOW:  r_low  <= wrap_inc(r_low, 3'(LOW_MAX));
                        SEL_NUM:  r_num  <= 2'(wrap_inc({1'b0, r_num}, 3'(NUM_MAX)));
                        default:  r_high <= r_high;
                    endcase
                end
                if ((r_state == PAY) && (|w_coin_evt)) begin
                    r_coin_pulse <= 1'b1;
                    if (w_coin_evt[0]) begin
                        r_coin_value <= COIN_1;
                    end else if (w_coin_evt[1]) begin
                        r_coin_value <= COIN_5;
                    end else begin
                        r_coin_value <= COIN_10;
                    end
                end
            end
        end
    end

    assign in_goods_high = r_high;
    assign in_goods_low  = r_low;
    assign in_goods_num  = r_num;
    assign entry_field   = r_state;
    assign sel_valid     = r_sel_valid;
    assign coin_pulse    = r_coin_pulse;
    assign coin_value    = r_coin_value;
    assign confirm_pulse = r_confirm_pulse;
    assign cancel_pulse  = r_cancel_pulse;

endmodule

// File: tb/tb_vending_key_input.sv
// Scoreboard bench for vending_key_input with short debounce/repeat periods.
`timescale 1ns/1ps
module tb_vending_key_input;

    localparam int DC = 4;
    localparam int RC = 20;

    localparam logic [6:0] K_UP   = 7'b0000001;
    localparam logic [6:0] K_NEXT = 7'b0000010;
    localparam logic [6:0] K_CONF = 7'b0000100;
    localparam logic [6:0] K_CANC = 7'b0001000;
    localparam logic [6:0] K_C1   = 7'b0010000;
    localparam logic [6:0] K_C5   = 7'b0100000;
    localparam logic [6:0] K_C10  = 7'b1000000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] raw = '0;
    logic       trade_done = 1'b0;
    logic [2:0] in_goods_high;
    logic [2:0] in_goods_low;
    logic [1:0] in_goods_num;
    logic [1:0] entry_field;
    logic       sel_valid;
    logic       coin_pulse;
    logic [3:0] coin_value;
    logic       confirm_pulse;
    logic       cancel_pulse;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    vending_key_input #(
        .DEBOUNCE_CYCLES(DC),
        .HIGH_MAX(3),
        .LOW_MAX(4),
        .NUM_MAX(3),
        .REPEAT_CYCLES(RC)
    ) dut (
        .sys_clk      (clk),
        .sys_rst_n    (rst_n),
        .key_up       (raw[0]),
        .key_next     (raw[1]),
        .key_confirm  (raw[2]),
        .key_cancel   (raw[3]),
        .key_coin     (raw[6:4]),
        .trade_done   (trade_done),
        .in_goods_high(in_goods_high),
        .in_goods_low (in_goods_low),
        .in_goods_num (in_goods_num),
        .entry_field  (entry_field),
        .sel_valid    (sel_valid),
        .coin_pulse   (coin_pulse),
        .coin_value   (coin_value),
        .confirm_pulse(confirm_pulse),
        .cancel_pulse (cancel_pulse)
    );

    typedef struct {
        string tag;
        int high, low, num, field, valid;
        int cpulse, cvalue, cfpulse, cnpulse;
        int at_cyc;
    } exp_t;

    exp_t sb_q[$];
    int checks = 0;
    int failures = 0;
    int m_high = 1, m_low = 1, m_num = 1, m_state = 0;

    task automatic check_value(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_high = 1; m_low = 1; m_num = 1; m_state = 0;
    endtask

    task automatic push_expect(input string tag, input int cp, input int cv, input int cf,
                               input int cn, input int at_cyc);
        exp_t e;
        e.tag = tag; e.high = m_high; e.low = m_low; e.num = m_num; e.field = m_state;
        e.valid = (m_state == 3) ? 1 : 0;
        e.cpulse = cp; e.cvalue = cv; e.cfpulse = cf; e.cnpulse = cn; e.at_cyc = at_cyc;
        sb_q.push_back(e);
    endtask

    // Expected reaction of the selection panel to one debounced key set.
    task automatic model_keys(input string tag, input logic [6:0] mask, input int at_cyc);
        int cp, cv, cf, cn;
        bit changed, pay;
        cp = 0; cv = 0; cf = 0; cn = 0; changed = 0;
        pay = (m_state == 3);
        if (mask[3]) begin
            model_reset(); cn = 1; changed = 1;
        end else begin
            if (mask[2]) begin
                if (m_state == 2) begin m_state = 3; changed = 1; end
                else if (pay) begin cf = 1; changed = 1; end
            end else if (mask[1]) begin
                if (!pay) begin m_state = (m_state == 2) ? 0 : m_state + 1; changed = 1; end
            end else if (mask[0]) begin
                if (!pay) begin
                    changed = 1;
                    case (m_state)
                        0: m_high = (m_high >= 3) ? 1 : m_high + 1;
                        1: m_low  = (m_low  >= 4) ? 1 : m_low + 1;
                        default: m_num = (m_num >= 3) ? 1 : m_num + 1;
                    endcase
                end
            end
            if (pay && (mask[6:4] != 3'b000)) begin
                cp = 1; changed = 1;
                cv = mask[4] ? 1 : (mask[5] ? 5 : 10);
            end
        end
        if (changed) push_expect(tag, cp, cv, cf, cn, at_cyc);
    endtask

    // Hold a key set for 'hold' cycles; 'events' debounced reactions are expected.
    task automatic press(input string tag, input logic [6:0] mask, input int hold,
                         input int events, input bit check_lat);
        @(negedge clk);
        for (int i = 0; i < events; i++) model_keys(tag, mask, (check_lat && i == 0) ? cyc + DC + 3 : -1);
        raw = mask;
        repeat (hold) @(negedge clk);
        raw = '0;
        repeat (12) @(negedge clk);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            check_value({tag, "_timeout"}, sb_q.size(), 0);
            sb_q.delete();
        end
    endtask

    function automatic logic [17:0] pack_outputs();
        return {in_goods_high, in_goods_low, in_goods_num, entry_field, sel_valid,
                coin_pulse, coin_value, confirm_pulse, cancel_pulse};
    endfunction

    // Monitor: any pulse, nonzero coin_value or selection change is one transaction.
    initial begin
        logic [17:0] cur, prev;
        exp_t e;
        prev = pack_outputs();
        forever begin
            @(negedge clk);
            cur = pack_outputs();
            if (rst_n && ((cur[6:0] != 7'd0) || (cur[17:7] != prev[17:7]))) begin
                if (sb_q.size() == 0) begin
                    check_value("spurious_output", int'(cur), int'(prev & 18'h3FF80));
                end else begin
                    e = sb_q.pop_front();
                    $display("txn %s @%0d: high=%0d low=%0d num=%0d field=%0d valid=%0d coin=%0d/%0d confirm=%0d cancel=%0d",
                             e.tag, cyc, in_goods_high, in_goods_low, in_goods_num, entry_field,
                             sel_valid, coin_pulse, coin_value, confirm_pulse, cancel_pulse);
                    check_value({e.tag, "_high"}, in_goods_high, e.high);
                    check_value({e.tag, "_low"}, in_goods_low, e.low);
                    check_value({e.tag, "_num"}, in_goods_num, e.num);
                    check_value({e.tag, "_field"}, entry_field, e.field);
                    check_value({e.tag, "_sel_valid"}, sel_valid, e.valid);
                    check_value({e.tag, "_coin_pulse"}, coin_pulse, e.cpulse);
                    check_value({e.tag, "_coin_value"}, coin_value, e.cvalue);
                    check_value({e.tag, "_confirm_pulse"}, confirm_pulse, e.cfpulse);
                    check_value({e.tag, "_cancel_pulse"}, cancel_pulse, e.cnpulse);
                    if (e.at_cyc >= 0) check_value({e.tag, "_latency"}, cyc, e.at_cyc);
                end
            end
            prev = cur;
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: cycle=%0d expected_end_before=%0d", cyc, 20000);
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_value("rst_high", in_goods_high, 1);
        check_value("rst_low", in_goods_low, 1);
        check_value("rst_num", in_goods_num, 1);
        check_value("rst_field", entry_field, 0);
        check_value("rst_sel_valid", sel_valid, 0);
        check_value("rst_coin_pulse", coin_pulse, 0);
        check_value("rst_coin_value", coin_value, 0);
        check_value("rst_confirm_pulse", confirm_pulse, 0);
        check_value("rst_cancel_pulse", cancel_pulse, 0);

        // Reset mid-debounce with the key still held: the press is lost.
        raw = K_UP;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        raw = '0;
        repeat (12) @(negedge clk);
        check_value("rst_lost_press_high", in_goods_high, 1);

        // Selection entry.
        press("up1", K_UP, 6, 1, 1);
        press("up2", K_UP, 6, 1, 0);
        press("next1", K_NEXT, 6, 1, 0);
        for (int i = 0; i < 3; i++) press("up_low", K_UP, 6, 1, 0);
        press("next2", K_NEXT, 6, 1, 0);
        press("up_num", K_UP, 6, 1, 0);
        press("confirm_sel", K_CONF, 6, 1, 0);
        wait_drain("sel");
        check_value("sel_final_high", in_goods_high, 3);
        check_value("sel_final_low", in_goods_low, 4);
        check_value("sel_final_num", in_goods_num, 2);
        check_value("sel_final_valid", sel_valid, 1);
        check_value("sel_final_field", entry_field, 3);

        // Coins and purchase confirm in PAY.
        press("coin10", K_C10, 6, 1, 0);
        press("coin1_5", K_C1 | K_C5, 6, 1, 0);
        press("confirm_pay", K_CONF, 6, 1, 0);
        wait_drain("pay");

        // Cancel beats confirm.
        press("cancel_conf", K_CANC | K_CONF, 6, 1, 0);
        wait_drain("cancel");
        check_value("cancel_field", entry_field, 0);
        check_value("cancel_valid", sel_valid, 0);

        // Coin outside PAY, glitch, and minimum-length press with latency.
        press("next_low", K_NEXT, 6, 1, 0);
        press("coin_sel", K_C1, 6, 0, 0);
        press("glitch", K_UP, DC - 1, 0, 0);
        press("press5", K_UP, 5, 1, 1);
        wait_drain("glitch");
        check_value("glitch_low", in_goods_low, 2);

        // High field wrap.
        press("next_num", K_NEXT, 6, 1, 0);
        press("next_high", K_NEXT, 6, 1, 0);
        for (int i = 0; i < 3; i++) press("wrap", K_UP, 6, 1, 0);
        wait_drain("wrap");
        check_value("wrap_high", in_goods_high, 1);

        // trade_done returns to SEL_HIGH without cancel_pulse.
        press("td_next1", K_NEXT, 6, 1, 0);
        press("td_next2", K_NEXT, 6, 1, 0);
        press("td_confirm", K_CONF, 6, 1, 0);
        wait_drain("td_setup");
        @(negedge clk);
        model_reset();
        push_expect("trade_done", 0, 0, 0, 0, cyc + 1);
        trade_done = 1'b1;
        @(negedge clk);
        trade_done = 1'b0;
        wait_drain("trade_done");

        // Long hold of key_up: repeat only when the feature is built in.
`ifdef VENDING_KEY_AUTO_REPEAT_EN
        press("hold_up", K_UP, DC + 2 + 65, 4, 1);
`else
        press("hold_up", K_UP, DC + 2 + 65, 1, 1);
`endif
        wait_drain("hold");
        repeat (40) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
